fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter PC_RESET, default 16'h0000, meaning PC value after reset.
REQ-002 SHALL have parameter TIMEOUT, default 15, meaning max wait cycles per byte for MemReady (used only with FETCH_TIMEOUT_EN).
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port Clock, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port Start, input, 1 bit: request fetch of one 16-bit instruction.
REQ-007 SHALL have port PCLoad, input, 1 bit: load PC from PCIn.
REQ-008 SHALL have port PCIn, input, 16 bits: branch/jump target.
REQ-009 SHALL have port MemData, input, 8 bits: memory read byte.
REQ-010 SHALL have port MemReady, input, 1 bit: MemData valid this cycle.
REQ-011 SHALL have port MemAddr, output, 16 bits: byte address, equal to PC.
REQ-012 SHALL have port MemRead, output, 1 bit: read request.
REQ-013 SHALL have port IRWrite, output, 1 bit: instruction register write strobe.
REQ-014 SHALL have port IRLH, output, 1 bit: 0 = low byte, 1 = high byte.
REQ-015 SHALL have port IRData, output, 8 bits: byte to instruction register.
REQ-016 SHALL have port Busy, output, 1 bit: fetch in progress.
REQ-017 SHALL have port Done, output, 1 bit: one-cycle fetch-complete pulse.
REQ-018 SHALL have port Fault, output, 1 bit: sticky fetch-timeout flag.

Function
REQ-019 SHALL implement FSM states IDLE, FETCH_LO, FETCH_HI, DONE.
REQ-020 SHALL transition IDLE->FETCH_LO on Start=1; FETCH_LO->FETCH_HI on MemReady=1; FETCH_HI->DONE on MemReady=1.
REQ-021 SHALL transition DONE->FETCH_LO if Start=1, else DONE->IDLE.
REQ-022 SHALL drive MemRead=1 and Busy=1 in FETCH_LO and FETCH_HI, and 0 otherwise.
REQ-023 SHALL drive combinationally, in FETCH_LO with MemReady=1: IRWrite=1, IRLH=0, IRData=MemData.
REQ-024 SHALL drive combinationally, in FETCH_HI with MemReady=1: IRWrite=1, IRLH=1, IRData=MemData.
REQ-025 SHALL drive IRWrite=0 in all other cases, with IRLH=0 and IRData=8'h00.
REQ-026 SHALL increment PC by 1 at the edge ending each accepted byte, so the low byte comes from PC and the high byte from PC+1.
REQ-027 SHALL wrap PC modulo 2^16 (16'hFFFF -> 16'h0000).
REQ-028 SHALL capture PC into an internal InstrAddr register on entering FETCH_LO.
REQ-029 SHALL drive Done=1 exactly in DONE.
REQ-030 SHALL honour PCLoad only in IDLE or DONE, ignoring it while Busy=1.
REQ-031 SHALL, when PCLoad and Start are both 1 in IDLE/DONE, load PC=PCIn and start the fetch from PCIn.
REQ-032 SHALL add a wait cycle for each cycle MemReady=0 in a fetch state, with no IR write and no PC change.

Reset
REQ-033 SHALL, on rst=0 at any time including mid-fetch, immediately set state=IDLE, PC=PC_RESET, InstrAddr=PC_RESET and Fault=0.
REQ-034 SHALL hold all strobes (MemRead, IRWrite, Busy, Done) at 0 while rst=0.
REQ-035 SHALL leave a partially written instruction register as-is after reset, with no further writes until the next Start.

Configuration
REQ-036 SHALL compile the timeout watchdog in only when FETCH_TIMEOUT_EN is defined.
REQ-037 SHALL, with FETCH_TIMEOUT_EN: clear a wait counter on entry to each fetch state and count each MemReady=0 cycle.
REQ-038 SHALL, with FETCH_TIMEOUT_EN, when the wait counter reaches TIMEOUT: go to IDLE, restore PC=InstrAddr, set Fault=1, with no Done pulse.
REQ-039 SHALL, with FETCH_TIMEOUT_EN, clear Fault on the next accepted Start.
REQ-040 SHALL, without FETCH_TIMEOUT_EN: wait indefinitely, keep Fault tied to 0, and include no counter logic.

Verification
REQ-041 SHALL test a basic fetch: PC=16'h0000, Start, MemReady=1 every cycle, bytes 8'h34, 8'h12 -> IRWrite on two consecutive cycles (IRLH 0 then 1), Done on cycle 3, PC=16'h0002.
REQ-042 SHALL test wait states: MemReady low 2 cycles before each byte -> Busy for 6 cycles, exactly two IRWrite pulses, PC advances by 2.
REQ-043 SHALL test wrap and load: PCLoad=1 with PCIn=16'hFFFF together with Start -> MemAddr FFFF then 0000, final PC=16'h0001; PCLoad during FETCH_HI is ignored.
REQ-044 SHALL test back-to-back fetch: Start held high -> DONE goes directly to FETCH_LO, two instructions in 6 cycles, Done pulses twice.
REQ-045 SHALL test reset mid-operation: rst=0 in FETCH_HI after low byte -> state IDLE, PC=PC_RESET, all strobes 0 asynchronously.
REQ-046 SHALL test timeout with FETCH_TIMEOUT_EN and TIMEOUT=15: low byte accepted at PC=16'h0010, MemReady held 0 for 15 cycles -> Fault=1, PC=16'h0010, no Done; next Start clears Fault.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Two-byte instruction fetch sequencer: reads low then high byte at PC, PC+1 and strobes the IR.
// Optional watchdog enabled by defining FETCH_TIMEOUT_EN.
module fetch_sequencer #(
    parameter logic [15:0] PC_RESET = 16'h0000,
    parameter int          TIMEOUT  = 15
) (
    input  logic        Clock,
    input  logic        rst,
    input  logic        Start,
    input  logic        PCLoad,
    input  logic [15:0] PCIn,
    input  logic [7:0]  MemData,
    input  logic        MemReady,
    output logic [15:0] MemAddr,
    output logic        MemRead,
    output logic        IRWrite,
    output logic        IRLH,
    output logic [7:0]  IRData,
    output logic        Busy,
    output logic        Done,
    output logic        Fault
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH_LO = 2'd1,
        FETCH_HI = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t      state_q;
    logic [15:0] pc_q;
    logic [15:0] instr_addr_q;
    logic        busy_q;
    logic        done_q;

    if (TIMEOUT < 1) begin : g_timeout_range
        $error("fetch_sequencer: TIMEOUT must be at least 1");
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    logic [WAIT_W-1:0] wait_q;
    logic              fault_q;
`endif

    // Fetch FSM, PC, captured instruction address and registered strobes
    always_ff @(posedge Clock or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            pc_q         <= PC_RESET;
            instr_addr_q <= PC_RESET;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            wait_q       <= '0;
            fault_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (Start) begin
                        state_q      <= FETCH_LO;
                        busy_q       <= 1'b1;
                        pc_q         <= PCLoad ? PCIn : pc_q;
                        instr_addr_q <= PCLoad ? PCIn : pc_q;
`ifdef FETCH_TIMEOUT_EN
                        wait_q       <= '0;
                        fault_q      <= 1'b0;
`endif
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        pc_q    <= PCLoad ? PCIn : pc_q;
                    end
                end
                FETCH_LO, FETCH_HI: begin
                    if (MemReady) begin
                        pc_q <= pc_q + 16'd1;
`ifdef FETCH_TIMEOUT_EN
                        wait_q <= '0;
`endif
                        if (state_q == FETCH_LO) begin
                            state_q <= FETCH_HI;
                        end else begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
`ifdef FETCH_TIMEOUT_EN
                        // Abandon the instruction and rewind PC so a retry refetches both bytes
                        if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            pc_q    <= instr_addr_q;
                            fault_q <= 1'b1;
                            wait_q  <= '0;
                        end else begin
                            wait_q <= wait_q + 1'b1;
                        end
`else
                        state_q <= state_q;
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Instruction-register write port, valid in the same cycle as the memory byte
    always_comb begin
        IRWrite = 1'b0;
        IRLH    = 1'b0;
        IRData  = 8'h00;
        if (MemReady && ((state_q == FETCH_LO) || (state_q == FETCH_HI))) begin
            IRWrite = 1'b1;
            IRLH    = (state_q == FETCH_HI);
            IRData  = MemData;
        end else begin
            IRWrite = 1'b0;
            IRLH    = 1'b0;
            IRData  = 8'h00;
        end
    end

    assign MemAddr = pc_q;
    assign MemRead = busy_q;
    assign Busy    = busy_q;
    assign Done    = done_q;

`ifdef FETCH_TIMEOUT_EN
    assign Fault = fault_q;
`else
    assign Fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus random traffic against a transaction-level model.
module tb_fetch_sequencer;

    logic        Clock = 1'b0;
    logic        rst;
    logic        Start, PCLoad, MemReady;
    logic [15:0] PCIn;
    logic [7:0]  MemData;
    logic [15:0] MemAddr;
    logic        MemRead, IRWrite, IRLH, Busy, Done, Fault;
    logic [7:0]  IRData;

    int checks   = 0;
    int failures = 0;

    // Reference model: bytes still owed for the current instruction, PC, and completion flag
    int          m_left;
    logic [15:0] m_pc;
    bit          m_done;

    fetch_sequencer dut (
        .Clock(Clock), .rst(rst), .Start(Start), .PCLoad(PCLoad), .PCIn(PCIn),
        .MemData(MemData), .MemReady(MemReady), .MemAddr(MemAddr), .MemRead(MemRead),
        .IRWrite(IRWrite), .IRLH(IRLH), .IRData(IRData), .Busy(Busy), .Done(Done), .Fault(Fault)
    );

    always #5 Clock = ~Clock;

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic model_update(input bit s, input bit l, input logic [15:0] pin, input bit r);
        if (m_left == 0) begin
            if (l) m_pc = pin;
            m_done = 1'b0;
            if (s) m_left = 2;
        end else if (r) begin
            m_pc   = m_pc + 16'd1;
            m_left = m_left - 1;
            m_done = (m_left == 0);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; Start = 1'b1; PCLoad = 1'b0; PCIn = 16'h0000; MemReady = 1'b1; MemData = 8'hEE;
        #12;
        checks++; if (Busy !== 1'b0)        begin failures++; $display("FAIL reset_busy got=%0h exp=0", Busy); end
        checks++; if (MemRead !== 1'b0)     begin failures++; $display("FAIL reset_memread got=%0h exp=0", MemRead); end
        checks++; if (IRWrite !== 1'b0)     begin failures++; $display("FAIL reset_irwrite got=%0h exp=0", IRWrite); end
        checks++; if (Done !== 1'b0)        begin failures++; $display("FAIL reset_done got=%0h exp=0", Done); end
        checks++; if (Fault !== 1'b0)       begin failures++; $display("FAIL reset_fault got=%0h exp=0", Fault); end
        checks++; if (MemAddr !== 16'h0000) begin failures++; $display("FAIL reset_pc got=%0h exp=0000", MemAddr); end
        @(posedge Clock); #1;
        Start = 1'b0; MemReady = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic_fetch;
        Start = 1'b1; MemReady = 1'b1; MemData = 8'h34; #1;
        checks++; if (IRWrite !== 1'b0) begin failures++; $display("FAIL basic_idle_irwrite got=%0h exp=0", IRWrite); end
        tick();
        Start = 1'b0; #1;
        checks++; if ({IRWrite, IRLH} !== 2'b10) begin failures++; $display("FAIL basic_lo_strobe got=%b exp=10", {IRWrite, IRLH}); end
        checks++; if (IRData !== 8'h34)          begin failures++; $display("FAIL basic_lo_data got=%0h exp=34", IRData); end
        checks++; if (MemRead !== 1'b1)          begin failures++; $display("FAIL basic_memread got=%0h exp=1", MemRead); end
        tick();
        MemData = 8'h12; #1;
        checks++; if ({IRWrite, IRLH} !== 2'b11) begin failures++; $display("FAIL basic_hi_strobe got=%b exp=11", {IRWrite, IRLH}); end
        checks++; if (IRData !== 8'h12)          begin failures++; $display("FAIL basic_hi_data got=%0h exp=12", IRData); end
        checks++; if (MemAddr !== 16'h0001)      begin failures++; $display("FAIL basic_hi_addr got=%0h exp=0001", MemAddr); end
        tick();
        #1;
        checks++; if ({Done, Busy, IRWrite} !== 3'b100) begin failures++; $display("FAIL basic_done got=%b exp=100", {Done, Busy, IRWrite}); end
        checks++; if (IRData !== 8'h00)          begin failures++; $display("FAIL basic_idle_data got=%0h exp=00", IRData); end
        checks++; if (MemAddr !== 16'h0002)      begin failures++; $display("FAIL basic_final_pc got=%0h exp=0002", MemAddr); end
        tick();
        #1;
        checks++; if (Done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%0h exp=0", Done); end
        MemReady = 1'b0;
    endtask

    task automatic test_wait_states;
        logic [5:0] pat;
        int busy_n = 0;
        int wr_n   = 0;
        pat = 6'b100100;
        Start = 1'b1; MemReady = 1'b0;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            MemReady = pat[i]; MemData = 8'($urandom); #1;
            if (Busy) busy_n++;
            if (IRWrite) wr_n++;
            checks++;
            if (MemAddr !== ((i < 3) ? 16'h0002 : 16'h0003)) begin
                failures++; $display("FAIL wait_addr cycle=%0d got=%0h exp=%0h", i, MemAddr, (i < 3) ? 16'h0002 : 16'h0003);
            end
            tick();
        end
        MemReady = 1'b0; #1;
        checks++; if (busy_n !== 6)         begin failures++; $display("FAIL wait_busy_cycles got=%0d exp=6", busy_n); end
        checks++; if (wr_n !== 2)           begin failures++; $display("FAIL wait_irwrites got=%0d exp=2", wr_n); end
        checks++; if (Done !== 1'b1)        begin failures++; $display("FAIL wait_done got=%0h exp=1", Done); end
        checks++; if (MemAddr !== 16'h0004) begin failures++; $display("FAIL wait_pc got=%0h exp=0004", MemAddr); end
        tick();
    endtask

    task automatic test_wrap_load;
        PCLoad = 1'b1; PCIn = 16'hFFFF; Start = 1'b1; MemReady = 1'b0;
        tick();
        PCLoad = 1'b0; Start = 1'b0; MemReady = 1'b1; MemData = 8'h5A; #1;
        checks++; if (MemAddr !== 16'hFFFF) begin failures++; $display("FAIL wrap_lo_addr got=%0h exp=ffff", MemAddr); end
        tick();
        PCLoad = 1'b1; PCIn = 16'h1234; MemData = 8'hA5; #1;
        checks++; if (MemAddr !== 16'h0000) begin failures++; $display("FAIL wrap_hi_addr got=%0h exp=0000", MemAddr); end
        checks++; if (IRLH !== 1'b1)        begin failures++; $display("FAIL wrap_hi_irlh got=%0h exp=1", IRLH); end
        tick();
        PCLoad = 1'b0; MemReady = 1'b0; #1;
        checks++; if (MemAddr !== 16'h0001) begin failures++; $display("FAIL wrap_final_pc got=%0h exp=0001", MemAddr); end
        checks++; if (Done !== 1'b1)        begin failures++; $display("FAIL wrap_done got=%0h exp=1", Done); end
        tick();
    endtask

    task automatic test_back_to_back;
        int dn = 0;
        int wr = 0;
        Start = 1'b1; MemReady = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            Start = (i < 5); MemData = 8'(i); #1;
            if (Done) dn++;
            if (IRWrite) wr++;
            checks++;
            if (Busy !== ((i % 3) != 2)) begin
                failures++; $display("FAIL b2b_busy cycle=%0d got=%0h exp=%0h", i, Busy, (i % 3) != 2);
            end
            tick();
        end
        MemReady = 1'b0; #1;
        checks++; if (dn !== 2)             begin failures++; $display("FAIL b2b_done_pulses got=%0d exp=2", dn); end
        checks++; if (wr !== 4)             begin failures++; $display("FAIL b2b_irwrites got=%0d exp=4", wr); end
        checks++; if (MemAddr !== 16'h0005) begin failures++; $display("FAIL b2b_pc got=%0h exp=0005", MemAddr); end
        checks++; if ({Busy, Done} !== 2'b00) begin failures++; $display("FAIL b2b_idle got=%b exp=00", {Busy, Done}); end
    endtask

    task automatic test_reset_mid;
        Start = 1'b1; MemReady = 1'b1; MemData = 8'hC3;
        tick();
        Start = 1'b0;
        tick();
        #1;
        checks++; if ({Busy, IRLH} !== 2'b11) begin failures++; $display("FAIL rstmid_in_hi got=%b exp=11", {Busy, IRLH}); end
        #1 rst = 1'b0;
        #1;
        checks++; if ({MemRead, Busy, IRWrite, Done} !== 4'b0000) begin
            failures++; $display("FAIL rstmid_strobes got=%b exp=0000", {MemRead, Busy, IRWrite, Done});
        end
        checks++; if (MemAddr !== 16'h0000) begin failures++; $display("FAIL rstmid_pc got=%0h exp=0000", MemAddr); end
        @(posedge Clock); #1;
        rst = 1'b1; #1;
        tick();
        #1;
        checks++; if ({Busy, IRWrite} !== 2'b00) begin failures++; $display("FAIL rstmid_no_resume got=%b exp=00", {Busy, IRWrite}); end
        MemReady = 1'b0;
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout;
        PCLoad = 1'b1; PCIn = 16'h0010; Start = 1'b1; MemReady = 1'b0;
        tick();
        PCLoad = 1'b0; Start = 1'b0; MemReady = 1'b1;
        tick();
        MemReady = 1'b0;
        for (int i = 0; i < 15; i++) begin
            #1;
            checks++; if ({Busy, Done, Fault} !== 3'b100) begin
                failures++; $display("FAIL timeout_waiting cycle=%0d got=%b exp=100", i, {Busy, Done, Fault});
            end
            tick();
        end
        checks++; if ({Fault, Busy, Done} !== 3'b100) begin failures++; $display("FAIL timeout_fault got=%b exp=100", {Fault, Busy, Done}); end
        checks++; if (MemAddr !== 16'h0010)           begin failures++; $display("FAIL timeout_pc got=%0h exp=0010", MemAddr); end
        tick();
        checks++; if (Done !== 1'b0) begin failures++; $display("FAIL timeout_no_done got=%0h exp=0", Done); end
        Start = 1'b1;
        tick();
        Start = 1'b0; #1;
        checks++; if (Fault !== 1'b0) begin failures++; $display("FAIL timeout_clear got=%0h exp=0", Fault); end
        MemReady = 1'b1;
        tick(); tick();
        MemReady = 1'b0;
        tick();
    endtask
`else
    task automatic test_no_timeout;
        Start = 1'b1; MemReady = 1'b0;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        checks++; if ({Busy, Fault, Done} !== 3'b100) begin failures++; $display("FAIL notimeout_wait got=%b exp=100", {Busy, Fault, Done}); end
        checks++; if (MemAddr !== 16'h0000)           begin failures++; $display("FAIL notimeout_pc got=%0h exp=0000", MemAddr); end
        MemReady = 1'b1;
        tick(); tick();
        MemReady = 1'b0; #1;
        checks++; if (Done !== 1'b1)        begin failures++; $display("FAIL notimeout_done got=%0h exp=1", Done); end
        checks++; if (MemAddr !== 16'h0002) begin failures++; $display("FAIL notimeout_final_pc got=%0h exp=0002", MemAddr); end
        tick();
    endtask
`endif

    task automatic test_random;
        bit         e_busy, e_wr;
        logic [7:0] e_data;
        int         zeros = 0;
        rst = 1'b0; Start = 1'b0; PCLoad = 1'b0; MemReady = 1'b0;
        #2 rst = 1'b1;
        m_left = 0; m_pc = 16'h0000; m_done = 1'b0;
        tick();
        for (int c = 0; c < 300; c++) begin
            Start    = ($urandom_range(0, 1) == 1);
            PCLoad   = ($urandom_range(0, 3) == 0);
            PCIn     = 16'($urandom);
            MemReady = (zeros >= 4) ? 1'b1 : ($urandom_range(0, 9) < 6);
            MemData  = 8'($urandom);
            #1;
            e_busy = (m_left != 0);
            e_wr   = e_busy && MemReady;
            e_data = e_wr ? MemData : 8'h00;
            checks++; if (Busy !== e_busy)          begin failures++; $display("FAIL rand_busy c=%0d got=%0h exp=%0h", c, Busy, e_busy); end
            checks++; if (MemRead !== e_busy)       begin failures++; $display("FAIL rand_memread c=%0d got=%0h exp=%0h", c, MemRead, e_busy); end
            checks++; if (IRWrite !== e_wr)         begin failures++; $display("FAIL rand_irwrite c=%0d got=%0h exp=%0h", c, IRWrite, e_wr); end
            checks++; if (IRLH !== (e_wr && m_left == 1)) begin failures++; $display("FAIL rand_irlh c=%0d got=%0h exp=%0h", c, IRLH, e_wr && m_left == 1); end
            checks++; if (IRData !== e_data)        begin failures++; $display("FAIL rand_irdata c=%0d got=%0h exp=%0h", c, IRData, e_data); end
            checks++; if (Done !== m_done)          begin failures++; $display("FAIL rand_done c=%0d got=%0h exp=%0h", c, Done, m_done); end
            checks++; if (MemAddr !== m_pc)         begin failures++; $display("FAIL rand_pc c=%0d got=%0h exp=%0h", c, MemAddr, m_pc); end
            checks++; if (Fault !== 1'b0)           begin failures++; $display("FAIL rand_fault c=%0d got=%0h exp=0", c, Fault); end
            zeros = (e_busy && !MemReady) ? zeros + 1 : 0;
            model_update(Start, PCLoad, PCIn, MemReady);
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_wait_states();
        test_wrap_load();
        test_back_to_back();
        test_reset_mid();
`ifdef FETCH_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
